// File: rtl/piso_serializer.sv
// piso_serializer
//   Parallel-in serial-out transmitter. A WIDTH-bit word is accepted over a
//   valid/ready handshake and shifted out one bit per clock. serial_valid
//   qualifies each frame bit and done pulses for one cycle after the frame.
//
// Parameters
//   WIDTH      word length in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//
// Optional feature
//   PISO_PARITY_EN  when defined, an even-parity bit (XOR of the word) is
//                   appended after the last data bit.
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   load_valid    upstream word available on load_data
//   load_data     word to transmit, sampled only on handshake
//   load_ready    block can accept a word (combinational, high in IDLE only)
//   serial_out    registered serial bit
//   serial_valid  serial_out carries a frame bit this cycle
//   busy          frame in progress
//   done          single-cycle end-of-frame pulse
//
// States
//   IDLE   | waiting for a word, load_ready high
//   SHIFT  | data bits on serial_out, counter holds bits still to send
//   PARITY | parity bit on serial_out (PISO_PARITY_EN only)

module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             so_nxt, sv_nxt, busy_nxt, done_nxt;
  logic             load_head, shreg_head;
  logic [WIDTH-1:0] load_rest, shreg_rest;
`ifdef PISO_PARITY_EN
  logic             par, par_nxt;
`endif

  // The shift register always presents the next bit at the same end, so the
  // transmit order is fixed purely by which end we read and which way we shift.
  always_comb begin
    if (MSB_FIRST) begin
      load_head  = load_data[WIDTH-1];
      load_rest  = load_data << 1;
      shreg_head = shreg[WIDTH-1];
      shreg_rest = shreg << 1;
    end else begin
      load_head  = load_data[0];
      load_rest  = load_data >> 1;
      shreg_head = shreg[0];
      shreg_rest = shreg >> 1;
    end
  end

  assign load_ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    so_nxt    = 1'b0;
    sv_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
`ifdef PISO_PARITY_EN
    par_nxt   = par;
`endif
    case (state)
      IDLE: begin
        if (load_valid) begin
          so_nxt    = load_head;
          sv_nxt    = 1'b1;
          busy_nxt  = 1'b1;
          shreg_nxt = load_rest;
          cnt_nxt   = CW'(WIDTH - 1);
          state_nxt = SHIFT;
`ifdef PISO_PARITY_EN
          par_nxt   = ^load_data;
`endif
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          so_nxt    = shreg_head;
          sv_nxt    = 1'b1;
          busy_nxt  = 1'b1;
          shreg_nxt = shreg_rest;
          cnt_nxt   = cnt - CW'(1);
        end else begin
`ifdef PISO_PARITY_EN
          so_nxt    = par;
          sv_nxt    = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = PARITY;
`else
          done_nxt  = 1'b1;
          state_nxt = IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shreg        <= '0;
      cnt          <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef PISO_PARITY_EN
      par          <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      shreg        <= shreg_nxt;
      cnt          <= cnt_nxt;
      serial_out   <= so_nxt;
      serial_valid <= sv_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
`ifdef PISO_PARITY_EN
      par          <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer
//   Drives two serializers (MSB-first and LSB-first, WIDTH=4) from the same
//   inputs. A cycle table covers plain frames, ignored inputs while busy and
//   back-to-back frames; hand-written sequences cover reset and mid-frame abort.
//   Set PISO_PARITY_EN for the parity build; the expected tables follow it.

module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic [3:0] load_data;
  logic       rdy_a, so_a, sv_a, busy_a, done_a;
  logic       rdy_b, so_b, sv_b, busy_b, done_b;

  int vec_count  = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(rdy_a), .serial_out(so_a), .serial_valid(sv_a),
    .busy(busy_a), .done(done_a)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(rdy_b), .serial_out(so_b), .serial_valid(sv_b),
    .busy(busy_b), .done(done_b)
  );

  typedef struct {
    logic       lv;
    logic [3:0] ld;
    logic       ea;   // expected serial_out, MSB-first instance
    logic       eb;   // expected serial_out, LSB-first instance
    logic       sv;
    logic       bz;
    logic       dn;
    logic       rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic lv, input logic [3:0] ld,
                              input logic ea, input logic eb, input logic sv,
                              input logic bz, input logic dn, input logic rd);
    vec_t v;
    v.lv = lv; v.ld = ld; v.ea = ea; v.eb = eb;
    v.sv = sv; v.bz = bz; v.dn = dn; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic ea, input logic eb,
                     input logic sv, input logic bz, input logic dn, input logic rd);
    logic [9:0] act, exp;
    act = {so_a, sv_a, busy_a, done_a, rdy_a, so_b, sv_b, busy_b, done_b, rdy_b};
    exp = {ea, sv, bz, dn, rd, eb, sv, bz, dn, rd};
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got {so,sv,busy,done,rdy}a/b=%b_%b required %b_%b",
               name, $time, act[9:5], act[4:0], exp[9:5], exp[4:0]);
    end
  endtask

  // exp_a/exp_b list the serial bits in transmit order, leftmost first.
  task automatic run_frame(input string name, input logic [3:0] d,
                           input logic [3:0] exp_a, input logic [3:0] exp_b,
                           input logic exp_par);
    load_valid = 1'b1;
    load_data  = d;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk(name, exp_a[3-i], exp_b[3-i], 1'b1, 1'b1, 1'b0, 1'b0);
      load_valid = 1'b0;
      load_data  = ~d;
    end
`ifdef PISO_PARITY_EN
    @(posedge clk); #1;
    chk({name, "_par"}, exp_par, exp_par, 1'b1, 1'b1, 1'b0, 1'b0);
`endif
    @(posedge clk); #1;
    chk({name, "_done"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk({name, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // 1011, inputs held with junk while busy, then 1100 and 0011 back to back
    vecs.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 4'b1011, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 4'b0000, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 4'b0000, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 4'b0000, 1, 1, 1, 1, 0, 0));
`ifdef PISO_PARITY_EN
    vecs.push_back(mk(1, 4'b0000, 1, 1, 1, 1, 0, 0));
`endif
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 4'b1100, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 4'b0011, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 4'b0011, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 4'b0011, 0, 1, 1, 1, 0, 0));
`ifdef PISO_PARITY_EN
    vecs.push_back(mk(1, 4'b0011, 0, 0, 1, 1, 0, 0));
`endif
    vecs.push_back(mk(1, 4'b0011, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 4'b0011, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 1, 1, 0, 0));
`ifdef PISO_PARITY_EN
    vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 1, 0, 0));
`endif
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0, 0, 1));

    // reset held with random inputs
    rst_n      = 1'b0;
    load_valid = 1'b1;
    load_data  = 4'b1111;
    #2;
    chk("reset_async", 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset_hold", 0, 0, 0, 0, 0, 1);
      load_valid = 1'($urandom_range(1));
      load_data  = 4'($urandom);
    end
    @(negedge clk);
    rst_n      = 1'b1;
    load_valid = 1'b0;
    load_data  = 4'h0;

    foreach (vecs[i]) begin
      load_valid = vecs[i].lv;
      load_data  = vecs[i].ld;
      @(posedge clk); #1;
      chk($sformatf("table_row%0d", i), vecs[i].ea, vecs[i].eb,
          vecs[i].sv, vecs[i].bz, vecs[i].dn, vecs[i].rd);
    end

    // abort 1111 after its second bit
    load_valid = 1'b1;
    load_data  = 4'b1111;
    @(posedge clk); #1;
    chk("abort_bit1", 1, 1, 1, 1, 0, 0);
    load_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_bit2", 1, 1, 1, 1, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_async_clear", 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("abort_no_done", 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle", 0, 0, 0, 0, 0, 1);

    run_frame("after_abort_0101", 4'b0101, 4'b0101, 4'b1010, 1'b0);
    run_frame("frame_1001",       4'b1001, 4'b1001, 4'b1001, 1'b0);
    run_frame("frame_1011",       4'b1011, 4'b1011, 4'b1101, 1'b1);
    run_frame("frame_0111",       4'b0111, 4'b0111, 4'b1110, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock.
- Provides a serial_valid qualifier and an end-of-frame pulse.
- Drives the serial input of downstream shift-register chains and serial receivers in the shift-register practice set.

Parameters:
- WIDTH, 4, word length in bits (>= 2).
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_valid  input  1  upstream has a word on load_data.
- load_data  input  WIDTH  word to transmit; sampled only on handshake.
- load_ready  output  1  block can accept a word.
- serial_out  output  1  registered serial bit.
- serial_valid  output  1  serial_out carries a frame bit this cycle.
- busy  output  1  frame in progress.
- done  output  1  single-cycle end-of-frame pulse.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, serial_out=0, serial_valid=0, busy=0, done=0, shift register and bit counter cleared.
- All outputs are registered except load_ready, which is high in IDLE only (combinational decode of state).
- FSM states: IDLE, SHIFT, plus PARITY (only with the optional feature).
- IDLE:
  - Handshake fires on the edge where load_valid=1 and load_ready=1.
  - On that edge: first bit goes to serial_out, serial_valid=1, busy=1.
  - Remaining bits are loaded into the shift register, bit counter = WIDTH-1, state -> SHIFT.
- SHIFT: each edge with counter != 0 drives the next bit to serial_out and decrements the counter.
- End of frame (counter == 0 at an edge, no parity):
  - state -> IDLE, serial_out=0, serial_valid=0, busy=0, done=1 for exactly one cycle.
- Frame timing:
  - Handshake at edge T: bits appear after edges T..T+WIDTH-1, serial_valid high for exactly WIDTH cycles.
  - done and load_ready are high together in the first IDLE cycle.
  - Minimum frame period is WIDTH+1 cycles.
- Bit order:
  - MSB_FIRST=1: bit WIDTH-1 down to bit 0.
  - MSB_FIRST=0: bit 0 up to bit WIDTH-1.
- load_valid and load_data are ignored while busy; load_data changes mid-frame do not affect the frame.
- A handshake in the same cycle done is high is legal: the new frame's first bit follows immediately and done deasserts.
- Reset mid-frame: the frame is aborted and discarded, outputs return to reset values immediately, and no done pulse is generated.
- No counter wrap: the bit counter width is clog2(WIDTH) and it never decrements below 0.

Optional Feature:
- Macro PISO_PARITY_EN.
- Defined:
  - Even parity (XOR of the accepted word) is computed and stored at handshake.
  - After the last data bit the FSM enters PARITY for one cycle: serial_out = parity, serial_valid = 1.
  - done fires after PARITY; serial_valid spans WIDTH+1 cycles and the minimum period is WIDTH+2.
- Undefined: PARITY state and parity register are absent; behaviour is as above.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> serial_out=0, serial_valid=0, busy=0, done=0, load_ready=1; deassert -> still idle, no spurious serial_valid.
- WIDTH=4, MSB_FIRST=1, load 4'b1011 at edge T -> serial_out 1,0,1,1 over the 4 cycles after T, serial_valid high those 4 cycles only, done=1 in the 5th cycle.
- MSB_FIRST=0, load 4'b1011 -> serial_out 1,1,0,1; hold load_valid=1 with load_data=4'b0000 during the frame -> no effect, load_ready=0 throughout, next frame starts in the done cycle.
- Back-to-back: 4'b1100 then 4'b0011 with load_valid held -> serial stream 1,1,0,0,(gap, serial_valid=0),0,0,1,1; done pulses twice.
- Pull rst_n low after the 2nd bit of 4'b1111 -> outputs cleared asynchronously in the same cycle, no done; the next load of 4'b0101 transmits cleanly.
- PISO_PARITY_EN, load 4'b1011 -> 1,0,1,1 then parity 1, serial_valid high 5 cycles; 4'b1001 -> parity 0.
